// File: rtl/prim_pipe_chain.sv
// Pipelined XOR/NOT primitive chain: DEPTH registered stages, each applying a
// +1/-1 mod 4 step to every 2-bit lane, with bubble-collapsing valid/ready.
module prim_pipe_chain #(
  parameter int IO_PAIRS = 6,
  parameter int DEPTH    = 4,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*IO_PAIRS-1:0] in_data,
  input  logic                  in_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*IO_PAIRS-1:0] out_data,
  output logic                  out_dir,
  output logic [CW-1:0]         occupancy
);

  localparam int W = 2 * IO_PAIRS;

  // One primitive step per lane: b0 always inverts, b1 picks up the carry/borrow.
  function automatic logic [W-1:0] prim(input logic [W-1:0] x, input logic dir);
    logic [W-1:0] y;
    y = '0;
    for (int j = 0; j < IO_PAIRS; j++) begin
      y[2*j]   = ~x[2*j];
      y[2*j+1] = x[2*j+1] ^ x[2*j] ^ dir;
    end
    return y;
  endfunction

  logic [DEPTH-1:0] r_v;
  logic [W-1:0]     r_d [DEPTH];
  logic [DEPTH-1:0] r_r;
  logic [CW-1:0]    r_occ;

  logic [DEPTH-1:0] w_ld;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_v;
  logic [W-1:0]     w_src_d [DEPTH];
  logic [DEPTH-1:0] w_src_r;
  logic             w_in_fire;
  logic             w_out_fire;

  // Load chain walked from the output back so each stage sees its successor's ld.
  always_comb begin
    logic w_carry;
    w_ld    = '0;
    w_adv   = '0;
    w_carry = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_adv[k] = r_v[k] & w_carry;
      w_ld[k]  = ~r_v[k] | w_adv[k];
      w_carry  = w_ld[k];
    end
  end

  // Next contents offered to each stage: the input for stage 0, else the previous stage.
  always_comb begin
    w_src_v    = '0;
    w_src_r    = '0;
    w_src_v[0] = in_valid;
    w_src_d[0] = prim(in_data, in_dir);
    w_src_r[0] = in_dir;
    for (int k = 1; k < DEPTH; k++) begin
      w_src_v[k] = r_v[k-1];
      w_src_d[k] = prim(r_d[k-1], r_r[k-1]);
      w_src_r[k] = r_r[k-1];
    end
  end

  // Stage registers: a stage loads only when its ld is high, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ld[k]) begin
          r_v[k] <= w_src_v[k];
          r_d[k] <= w_src_d[k];
          r_r[k] <= w_src_r[k];
        end
      end
    end
  end

  assign w_in_fire  = in_valid & w_ld[0];
  assign w_out_fire = r_v[DEPTH-1] & out_ready;

  // Occupancy tracks popcount of r_v; simultaneous fires cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign out_dir   = r_r[DEPTH-1];
  assign occupancy = r_occ;

endmodule
